// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad emulator.
package hex_keypad_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESS_B = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_REL_B   = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StPressB = ST_PRESS_B,
    StHold   = ST_HOLD,
    StRelB   = ST_REL_B,
    StGap    = ST_GAP
  } state_e;

  localparam int unsigned ROW_MSB = 3;
  localparam int unsigned ROW_LSB = 2;
  localparam int unsigned COL_MSB = 1;
  localparam int unsigned COL_LSB = 0;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keycode_fifo.sv
// Synchronous key-code FIFO; extra pointer bit distinguishes full from empty.
module keycode_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad switch-matrix model: plays queued key codes as timed contact
// closures (with optional bounce) and answers scanner column strobes on row.
module hex_keypad_emulator
  import hex_keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned GAP_CYCLES    = 32,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       s_row,
  output logic       busy,
  output logic       key_done
);

  localparam int unsigned MaxHg  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxHg > BOUNCE_CYCLES) ? MaxHg : BOUNCE_CYCLES;
  localparam int unsigned CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] BounceLast =
      CntW'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cur_code_q, cur_code_d;
  logic            contact_q, contact_d;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [3:0]      fifo_data;

  keycode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (key_valid),
    .pop     (fifo_pop),
    .wr_data (key_code),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign key_ready = !fifo_full;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_code_d = cur_code_q;
    fifo_pop   = 1'b0;
    key_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_code_d = fifo_data;
          cnt_d      = '0;
          state_d    = (BOUNCE_CYCLES == 0) ? StHold : StPressB;
        end
      end
      StPressB: begin
        if (cnt_q == BounceLast) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = (BOUNCE_CYCLES == 0) ? StGap : StRelB;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRelB: begin
        if (cnt_q == BounceLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          key_done = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Contact is registered alongside the state it belongs to: press bounce
  // starts closed, release bounce starts open.
  always_comb begin
    contact_d = 1'b0;
    unique case (state_d)
      StPressB: contact_d = ~cnt_d[0];
      StHold:   contact_d = 1'b1;
      StRelB:   contact_d = cnt_d[0];
      default:  contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_code_q <= '0;
      contact_q  <= 1'b0;
      s_row      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_code_q <= cur_code_d;
      contact_q  <= contact_d;
      s_row      <= |row;
    end
  end

  assign row = (contact_q && col[cur_code_q[COL_MSB:COL_LSB]]) ?
               onehot4(cur_code_q[ROW_MSB:ROW_LSB]) : 4'b0000;

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Directed self-checking bench for hex_keypad_emulator (HOLD=64, GAP=32, BOUNCE=8, DEPTH=4).
module tb_hex_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [3:0] col = 4'b0000;
  logic [3:0] row;
  logic       s_row;
  logic       busy;
  logic       key_done;

  int checks = 0;
  int errors = 0;

  hex_keypad_emulator #(
    .HOLD_CYCLES   (64),
    .GAP_CYCLES    (32),
    .BOUNCE_CYCLES (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .s_row     (s_row),
    .busy      (busy),
    .key_done  (key_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (row !== 4'b0000) begin errors++; $display("FAIL reset_row got %b want 0000", row); end
    checks++; if (s_row !== 1'b0) begin errors++; $display("FAIL reset_s_row got %b want 0", s_row); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (key_done !== 1'b0) begin errors++; $display("FAIL reset_key_done got %b want 0", key_done); end
    rst = 1'b1;
    tick();
  endtask

  // Pop at n=0, press bounce n=1..8, hold n=9..72, release n=73..80, gap n=81..112.
  task automatic test_single_key();
    int done_at;
    int done_cnt;
    done_at  = -1;
    done_cnt = 0;
    col = 4'b0100;
    push_key(4'h6);
    for (int n = 0; n < 300; n++) begin
      if (key_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == 1) begin
        checks++; if (row !== 4'b0010) begin errors++; $display("FAIL single_first_close got %b want 0010", row); end
        checks++; if (s_row !== 1'b0) begin errors++; $display("FAIL single_s_row_lag got %b want 0", s_row); end
      end
      if (n == 2) begin
        checks++; if (s_row !== 1'b1) begin errors++; $display("FAIL single_s_row_rise got %b want 1", s_row); end
      end
      if (n == 40) begin
        checks++; if (row !== 4'b0010) begin errors++; $display("FAIL single_hold_row got %b want 0010", row); end
        checks++; if (s_row !== 1'b1) begin errors++; $display("FAIL single_hold_s_row got %b want 1", s_row); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
      end
      if (n == 100) begin
        checks++; if (row !== 4'b0000) begin errors++; $display("FAIL single_gap_row got %b want 0000", row); end
      end
      tick();
    end
    checks++; if (done_at != 112) begin errors++; $display("FAIL single_done_time got %0d want 112", done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_no_col();
    int nz;
    int hi;
    int dc;
    nz = 0; hi = 0; dc = 0;
    col = 4'b0001;
    push_key(4'h6);
    for (int n = 0; n < 200; n++) begin
      if (row !== 4'b0000) nz++;
      if (s_row !== 1'b0) hi++;
      if (key_done === 1'b1) dc++;
      tick();
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL nocol_row_cycles got %0d want 0", nz); end
    checks++; if (hi != 0) begin errors++; $display("FAIL nocol_s_row_cycles got %0d want 0", hi); end
    checks++; if (dc != 1) begin errors++; $display("FAIL nocol_done_count got %0d want 1", dc); end
  endtask

  task automatic test_bounce();
    int pe;
    int he;
    int re;
    logic [3:0] prev;
    pe = 0; he = 0; re = 0;
    col = 4'b0010;
    push_key(4'hD);
    prev = row;
    for (int n = 0; n < 200; n++) begin
      if (n > 0 && row !== prev) begin
        if (n >= 1 && n <= 8) pe++;
        else if (n >= 10 && n <= 72) he++;
        else if (n >= 73 && n <= 80) re++;
      end
      if (n == 30) begin
        checks++; if (row !== 4'b1000) begin errors++; $display("FAIL bounce_hold_row got %b want 1000", row); end
      end
      prev = row;
      tick();
    end
    checks++; if (pe != 8) begin errors++; $display("FAIL bounce_press_edges got %0d want 8", pe); end
    checks++; if (he != 0) begin errors++; $display("FAIL bounce_hold_edges got %0d want 0", he); end
    checks++; if (re != 8) begin errors++; $display("FAIL bounce_release_edges got %0d want 8", re); end
  endtask

  // A primer key occupies the FSM so four pushes fill the queue and the fifth is dropped.
  task automatic test_back_to_back();
    logic [3:0] codes [5];
    logic [3:0] exp_row [5];
    logic [3:0] last_row [5];
    int k;
    codes[0] = 4'hC; codes[1] = 4'h0; codes[2] = 4'h5; codes[3] = 4'hA; codes[4] = 4'hF;
    exp_row[0] = 4'b1000; exp_row[1] = 4'b0001; exp_row[2] = 4'b0010;
    exp_row[3] = 4'b0100; exp_row[4] = 4'b1000;
    for (int i = 0; i < 5; i++) last_row[i] = 4'b0000;
    k = 0;
    col = 4'b0001;
    push_key(4'hC);
    tick();
    tick();
    push_key(4'h0);
    push_key(4'h5);
    push_key(4'hA);
    push_key(4'hF);
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", key_ready); end
    push_key(4'h3);
    for (int n = 0; n < 800; n++) begin
      col = (k < 5) ? (4'b0001 << codes[k][1:0]) : 4'b0000;
      #1;
      if (k < 5 && row !== 4'b0000) last_row[k] = row;
      if (key_done === 1'b1) k++;
      tick();
    end
    checks++; if (k != 5) begin errors++; $display("FAIL b2b_done_count got %0d want 5", k); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (last_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL b2b_row_%0d got %b want %b", i, last_row[i], exp_row[i]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_hold();
    int dc;
    int nz;
    int bb;
    dc = 0; nz = 0; bb = 0;
    col = 4'b0100;
    push_key(4'h6);
    push_key(4'h9);
    for (int n = 1; n < 40; n++) tick();
    checks++; if (row !== 4'b0010) begin errors++; $display("FAIL rst_pre_row got %b want 0010", row); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (row !== 4'b0000) begin errors++; $display("FAIL rst_row got %b want 0000", row); end
    checks++; if (s_row !== 1'b0) begin errors++; $display("FAIL rst_s_row got %b want 0", s_row); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready got %b want 1", key_ready); end
    tick();
    rst = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (key_done === 1'b1) dc++;
      if (row !== 4'b0000) nz++;
      if (busy !== 1'b0) bb++;
      tick();
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL rst_after_done got %0d want 0", dc); end
    checks++; if (nz != 0) begin errors++; $display("FAIL rst_after_row got %0d want 0", nz); end
    checks++; if (bb != 0) begin errors++; $display("FAIL rst_after_busy got %0d want 0", bb); end
  endtask

  // Scanner-style walk of the column strobes during HOLD, decoding the key from row.
  task automatic test_all_codes();
    int hits;
    logic [3:0] dec;
    logic got;
    for (int c = 0; c < 16; c++) begin
      col = 4'b0000;
      push_key(4'(c));
      for (int n = 0; n < 30; n++) tick();
      hits = 0;
      dec  = 4'h0;
      for (int j = 0; j < 4; j++) begin
        col = 4'b0001 << j;
        #1;
        if (row !== 4'b0000) begin
          hits++;
          for (int r = 0; r < 4; r++) if (row[r] === 1'b1) dec = {2'(r), 2'(j)};
        end
      end
      col = 4'b0000;
      checks++; if (hits != 1) begin errors++; $display("FAIL scan_hits_%0d got %0d want 1", c, hits); end
      checks++; if (dec !== 4'(c)) begin errors++; $display("FAIL scan_code_%0d got %h want %h", c, dec, 4'(c)); end
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
        if (key_done === 1'b1) got = 1'b1;
        tick();
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL scan_done_%0d got %b want 1", c, got); end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_no_col();
    test_bounce();
    test_back_to_back();
    test_reset_mid_hold();
    test_all_codes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
